lfsr_multistep: RTL and testbench
=================================

Name: lfsr_multistep

Overview:
Parametrised maximal-length Fibonacci LFSR pseudo-random generator. Successor to the fixed single-step lfsr.
- Width is generic over 3..32 bits with a built-in maximal tap table.
- Advances STEPS_PER_CLK shifts per enabled clock.
- Guards against the XNOR lockup seed.
- Flags sequence wrap back to the active reference state.
Feeds test-pattern and dither sources in the MAX7219 framebuffer design.

Parameters:
NUM_BITS, 4, LFSR width; legal 3..32, else elaboration error.
STEPS_PER_CLK, 1, LFSR shifts per enabled clock; legal 1..NUM_BITS.
CNT_BITS, 32, width of optional period counter.

Ports:
i_Clk  in  1  clock; all logic on rising edge.
i_Rst  in  1  synchronous, active-high reset.
i_Enable  in  1  advance LFSR this clock.
i_Seed_DV  in  1  one-cycle strobe: load i_Seed_Data.
i_Seed_Data  in  NUM_BITS  seed value.
o_LFSR_Data  out  NUM_BITS  registered LFSR state.
o_LFSR_Done  out  1  one-cycle pulse: sequence returned to reference state.
o_Seed_Err  out  1  one-cycle pulse: lockup seed rejected.
o_Period_Cnt  out  CNT_BITS  enabled clocks since last reference or wrap (optional; see below).

Behaviour:
- Single shift: S_next = {S[NUM_BITS-2:0], fb}.
- fb = XNOR of tap bits, 1-based, XAPP052 maximal-length taps. Examples: 4:(4,3) giving fb = ~(S[3]^S[2]); 8:(8,6,5,4); 16:(16,15,13,4); 32:(32,22,2,1). Full table 3..32 held in a function.
- Lockup state: all-ones. Period from any other state: 2^NUM_BITS-1.
- Per enabled clock: STEPS_PER_CLK chained shifts combinationally (intermediates I1..Ik, k=STEPS_PER_CLK). o_LFSR_Data <= Ik.
- Internal register REF holds the reference state.
- Reset (i_Rst=1, highest priority): o_LFSR_Data=0, REF=0, o_LFSR_Done=0, o_Seed_Err=0, o_Period_Cnt=0.
- Seed load (i_Seed_DV=1, priority over i_Enable), effective next clock:
  - Normal seed: o_LFSR_Data <= seed, REF <= seed. No step taken that clock.
  - All-ones seed: load all-zeros into o_LFSR_Data and REF instead; o_Seed_Err=1 for that one cycle.
  - o_LFSR_Done=0 on the load cycle.
- Step (i_Enable=1, no seed): o_LFSR_Done <= 1 if any Ij == REF, else 0. Registered, coincident with the new o_LFSR_Data.
- i_Enable=0 and no seed: state holds; o_LFSR_Done and o_Seed_Err return to 0.
- Mid-sequence reset or seed aborts immediately; no partial step is retained.
- Latency: one clock from input strobe to output.

Optional Feature:
LFSR_PERIOD_CNT_EN
- Defined: o_Period_Cnt increments by 1 per enabled step clock and wraps at 2^CNT_BITS. Cleared to 0 on reset, on seed load, and in the cycle o_LFSR_Done asserts (next step then gives 1).
- Undefined: counter logic absent; o_Period_Cnt tied to 0.

Test Plan:
1. NUM_BITS=4, STEPS=1, reset then enable constantly -> o_LFSR_Data 0001,0011,0111,1110,1101,1011,0110,1100,1001,0010,0101,1010,0100,1000,0000. o_LFSR_Done=1 exactly on the 0000 cycle (15th clock), then repeats every 15 clocks.
2. NUM_BITS=4, STEPS=2, reset then enable -> first outputs 0011,1110,1011. o_LFSR_Done on the 8th and 15th enabled clocks, period 15 clocks thereafter.
3. Seed 0110 with i_Enable=1 in the same cycle -> next o_LFSR_Data=0110 (no step), Done=0. Done next pulses 15 clocks later with data=0110.
4. Seed 1111 -> o_LFSR_Data=0000, o_Seed_Err=1 for one cycle, sequence resumes per scenario 1.
5. Assert i_Rst at step 7, with i_Enable held -> next cycle all outputs 0; sequence restarts at 0001.
6. NUM_BITS=8, 16 and 32, STEPS=1, with LFSR_PERIOD_CNT_EN:
   - Done interval = 255 / 65535 clocks for 8 / 16 bits.
   - o_Period_Cnt reaches 254 / 65534 just before Done.
   - 32-bit: no all-ones state within 10^6 clocks.
   - Without the macro, o_Period_Cnt stays 0.

Source files
------------

// File: rtl/lfsr_multistep.sv
// Maximal-length XNOR Fibonacci LFSR, NUM_BITS 3..32, advancing STEPS_PER_CLK
// shifts per enabled clock, with lockup-seed guard and wrap detection.
//
// Ports:
//   i_Clk         clock, rising edge
//   i_Rst         synchronous active-high reset
//   i_Enable      advance the LFSR this clock
//   i_Seed_DV     one-cycle strobe to load i_Seed_Data
//   i_Seed_Data   seed value
//   o_LFSR_Data   registered LFSR state
//   o_LFSR_Done   pulse: a shift this clock reached the reference state
//   o_Seed_Err    pulse: all-ones lockup seed was rejected (zeros loaded)
//   o_Period_Cnt  enabled clocks since last reference/wrap
//
// Optional: define LFSR_PERIOD_CNT_EN to build the period counter;
// otherwise o_Period_Cnt is tied to zero.

module lfsr_multistep #(
  parameter int NUM_BITS      = 4,
  parameter int STEPS_PER_CLK = 1,
  parameter int CNT_BITS      = 32
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  output logic [NUM_BITS-1:0] o_LFSR_Data,
  output logic                o_LFSR_Done,
  output logic                o_Seed_Err,
  output logic [CNT_BITS-1:0] o_Period_Cnt
);

  generate
    if (NUM_BITS < 3 || NUM_BITS > 32) begin : g_bad_width
      $error("lfsr_multistep: NUM_BITS must be 3..32");
    end
    if (STEPS_PER_CLK < 1 || STEPS_PER_CLK > NUM_BITS) begin : g_bad_steps
      $error("lfsr_multistep: STEPS_PER_CLK must be 1..NUM_BITS");
    end
    if (CNT_BITS < 1) begin : g_bad_cnt
      $error("lfsr_multistep: CNT_BITS must be >= 1");
    end
  endgenerate

  // Build a mask from 1-based tap positions; 0 means unused slot.
  function automatic logic [31:0] taps(
    input int a,
    input int b,
    input int c,
    input int d
  );
    logic [31:0] m;
    m = '0;
    if (a > 0) m[5'(a-1)] = 1'b1;
    if (b > 0) m[5'(b-1)] = 1'b1;
    if (c > 0) m[5'(c-1)] = 1'b1;
    if (d > 0) m[5'(d-1)] = 1'b1;
    return m;
  endfunction

  // XAPP052 maximal-length tap table.
  function automatic logic [31:0] tap_mask(input int n);
    logic [31:0] m;
    m = '0;
    case (n)
      3:       m = taps(3, 2, 0, 0);
      4:       m = taps(4, 3, 0, 0);
      5:       m = taps(5, 3, 0, 0);
      6:       m = taps(6, 5, 0, 0);
      7:       m = taps(7, 6, 0, 0);
      8:       m = taps(8, 6, 5, 4);
      9:       m = taps(9, 5, 0, 0);
      10:      m = taps(10, 7, 0, 0);
      11:      m = taps(11, 9, 0, 0);
      12:      m = taps(12, 6, 4, 1);
      13:      m = taps(13, 4, 3, 1);
      14:      m = taps(14, 5, 3, 1);
      15:      m = taps(15, 14, 0, 0);
      16:      m = taps(16, 15, 13, 4);
      17:      m = taps(17, 14, 0, 0);
      18:      m = taps(18, 11, 0, 0);
      19:      m = taps(19, 6, 2, 1);
      20:      m = taps(20, 17, 0, 0);
      21:      m = taps(21, 19, 0, 0);
      22:      m = taps(22, 21, 0, 0);
      23:      m = taps(23, 18, 0, 0);
      24:      m = taps(24, 23, 22, 17);
      25:      m = taps(25, 22, 0, 0);
      26:      m = taps(26, 6, 2, 1);
      27:      m = taps(27, 5, 2, 1);
      28:      m = taps(28, 25, 0, 0);
      29:      m = taps(29, 27, 0, 0);
      30:      m = taps(30, 6, 4, 1);
      31:      m = taps(31, 28, 0, 0);
      32:      m = taps(32, 22, 2, 1);
      default: m = '0;
    endcase
    return m;
  endfunction

  localparam logic [31:0] TAP_ALL = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAPS = TAP_ALL[NUM_BITS-1:0];

  function automatic logic [NUM_BITS-1:0] lfsr_step(
    input logic [NUM_BITS-1:0] s
  );
    return {s[NUM_BITS-2:0], ~^(s & TAPS)};
  endfunction

  logic [NUM_BITS-1:0] r_data;
  logic [NUM_BITS-1:0] r_ref;
  logic                r_done;
  logic                r_err;

  logic [NUM_BITS-1:0] w_chain [0:STEPS_PER_CLK];
  logic                w_hit;
  logic                w_lock_seed;

  // Chain of shifts; a wrap is flagged if any intermediate lands on REF,
  // so multi-step clocks cannot skip over the reference state.
  always_comb begin
    w_hit      = 1'b0;
    w_chain[0] = r_data;
    for (int j = 0; j < STEPS_PER_CLK; j++) begin
      w_chain[j+1] = lfsr_step(w_chain[j]);
      if (w_chain[j+1] == r_ref) w_hit = 1'b1;
    end
  end

  assign w_lock_seed = &i_Seed_Data;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_data <= '0;
      r_ref  <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else if (i_Seed_DV) begin
      r_done <= 1'b0;
      if (w_lock_seed) begin
        r_data <= '0;
        r_ref  <= '0;
        r_err  <= 1'b1;
      end else begin
        r_data <= i_Seed_Data;
        r_ref  <= i_Seed_Data;
        r_err  <= 1'b0;
      end
    end else if (i_Enable) begin
      r_data <= w_chain[STEPS_PER_CLK];
      r_done <= w_hit;
      r_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end
  end

`ifdef LFSR_PERIOD_CNT_EN
  logic [CNT_BITS-1:0] r_cnt;

  // Cleared on the wrap clock so the next step reads 1.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_cnt <= '0;
    end else if (i_Seed_DV) begin
      r_cnt <= '0;
    end else if (i_Enable) begin
      if (w_hit) r_cnt <= '0;
      else       r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_Period_Cnt = r_cnt;
`else
  assign o_Period_Cnt = '0;
`endif

  assign o_LFSR_Data = r_data;
  assign o_LFSR_Done = r_done;
  assign o_Seed_Err  = r_err;

endmodule

// File: tb/tb_lfsr_multistep.sv
// Directed bench for lfsr_multistep: 4-bit single/dual step and 8-bit
// instances, checked against hand-written sequence tables.

module tb_lfsr_multistep;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       dv;
  logic [3:0] seed4;
  logic [7:0] seed8;

  logic [3:0]  a_data, b_data;
  logic        a_done, b_done, a_err, b_err;
  logic [31:0] a_cnt, b_cnt;
  logic [7:0]  c_data;
  logic        c_done, c_err;
  logic [31:0] c_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // 4-bit sequence by position from the all-zero state.
  logic [3:0] seq4 [0:14] = '{
    4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
    4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8
  };

  lfsr_multistep #(.NUM_BITS(4), .STEPS_PER_CLK(1), .CNT_BITS(32)) u_a (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Seed_DV(dv),
    .i_Seed_Data(seed4), .o_LFSR_Data(a_data), .o_LFSR_Done(a_done),
    .o_Seed_Err(a_err), .o_Period_Cnt(a_cnt)
  );

  lfsr_multistep #(.NUM_BITS(4), .STEPS_PER_CLK(2), .CNT_BITS(32)) u_b (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Seed_DV(dv),
    .i_Seed_Data(seed4), .o_LFSR_Data(b_data), .o_LFSR_Done(b_done),
    .o_Seed_Err(b_err), .o_Period_Cnt(b_cnt)
  );

  lfsr_multistep #(.NUM_BITS(8), .STEPS_PER_CLK(1), .CNT_BITS(32)) u_c (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Seed_DV(dv),
    .i_Seed_Data(seed8), .o_LFSR_Data(c_data), .o_LFSR_Done(c_done),
    .o_Seed_Err(c_err), .o_Period_Cnt(c_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int v);
`ifdef LFSR_PERIOD_CNT_EN
    return 32'(v);
`else
    return (v == v) ? 32'd0 : 32'd1;
`endif
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; dv = 1'b0; seed4 = '0; seed8 = '0;
    tick();
    tick();
    chk("rst_data", 32'(a_data), 32'h0);
    chk("rst_done", 32'(a_done), 32'h0);
    chk("rst_err",  32'(a_err),  32'h0);
    chk("rst_cnt",  a_cnt,       32'h0);
    chk("rst_c",    32'(c_data), 32'h0);

    rst = 1'b0; en = 1'b1;
    for (int i = 1; i <= 510; i++) begin
      tick();
      chk("s1_data", 32'(a_data), 32'(seq4[i % 15]));
      chk("s1_done", 32'(a_done), 32'((i % 15) == 0));
      chk("s1_cnt",  a_cnt,       cnt_exp(i % 15));
      chk("s2_data", 32'(b_data), 32'(seq4[(2*i) % 15]));
      chk("s2_done", 32'(b_done),
          32'(((2*i) % 15) == 0 || ((2*i-1) % 15) == 0));
      chk("b8_done", 32'(c_done), 32'((i % 255) == 0));
      chk("b8_cnt",  c_cnt,       cnt_exp(i % 255));
      if (i % 255 == 0) chk("b8_wrap", 32'(c_data), 32'h0);
    end

    // Seed with enable in the same cycle: load only, no step.
    dv = 1'b1; seed4 = 4'h6; seed8 = 8'h5A;
    tick();
    dv = 1'b0;
    chk("sd_data", 32'(a_data), 32'h6);
    chk("sd_done", 32'(a_done), 32'h0);
    chk("sd_err",  32'(a_err),  32'h0);
    chk("sd_cnt",  a_cnt,       32'h0);
    chk("sd_c",    32'(c_data), 32'h5A);
    for (int j = 1; j <= 15; j++) begin
      tick();
      chk("sq_data", 32'(a_data), 32'(seq4[(7+j) % 15]));
      chk("sq_done", 32'(a_done), 32'(j == 15));
      chk("sq_cnt",  a_cnt,       cnt_exp(j % 15));
    end

    en = 1'b0;
    tick();
    chk("hold_data", 32'(a_data), 32'h6);
    chk("hold_done", 32'(a_done), 32'h0);
    chk("hold_cnt",  a_cnt,       32'h0);

    // Lockup seed is replaced by zeros.
    en = 1'b1; dv = 1'b1; seed4 = 4'hF; seed8 = 8'hFF;
    tick();
    dv = 1'b0;
    chk("lk_data",  32'(a_data), 32'h0);
    chk("lk_err",   32'(a_err),  32'h1);
    chk("lk_done",  32'(a_done), 32'h0);
    chk("lk_c",     32'(c_data), 32'h0);
    chk("lk_c_err", 32'(c_err),  32'h1);
    for (int j = 1; j <= 6; j++) begin
      tick();
      chk("lk_seq", 32'(a_data), 32'(seq4[j]));
      chk("lk_err0", 32'(a_err), 32'h0);
      chk("lk_cnt", a_cnt,       cnt_exp(j));
    end

    // Reset on the 7th step with enable held.
    rst = 1'b1;
    tick();
    chk("mr_data", 32'(a_data), 32'h0);
    chk("mr_done", 32'(a_done), 32'h0);
    chk("mr_err",  32'(a_err),  32'h0);
    chk("mr_cnt",  a_cnt,       32'h0);
    chk("mr_b",    32'(b_data), 32'h0);
    rst = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      tick();
      chk("mr_seq", 32'(a_data), 32'(seq4[j]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
